// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the piso_serializer block.
//   state_t          : shifter state (IDLE / SHIFTING)
//   symbols_per_word : number of symbols carried by one parallel word
//   params_ok        : parameter legality test used at elaboration by the top
package piso_serializer_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_t;

  function automatic int symbols_per_word(input int width, input int symbol_bits);
    return width / symbol_bits;
  endfunction

  // SYMBOL_BITS must divide WIDTH and a word must hold at least two symbols.
  function automatic bit params_ok(input int width, input int symbol_bits);
    return (symbol_bits > 0) && ((width % symbol_bits) == 0) &&
           ((width / symbol_bits) >= 2);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift register, symbol counter and symbol select for piso_serializer.
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   load, load_word  : load a fresh word and restart the symbol counter
//   shift            : advance one symbol toward the output end
//   enable           : output gate; symbol reads 0 when low
//   symbol           : current symbol (low or high end depending on MSB_FIRST)
//   last             : counter is on the final symbol of the word
module piso_shift_core
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYMBOL_BITS = 1,
  parameter int MSB_FIRST   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_word,
  input  logic                   shift,
  input  logic                   enable,
  output logic [SYMBOL_BITS-1:0] symbol,
  output logic                   last
);

  localparam int SYMBOLS = symbols_per_word(WIDTH, SYMBOL_BITS);
  localparam int CNT_W   = $clog2(SYMBOLS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOLS - 1);

  logic [WIDTH-1:0]       shreg;
  logic [CNT_W-1:0]       cnt;
  logic [SYMBOL_BITS-1:0] head;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_word;
      cnt   <= '0;
    end else if (shift) begin
      if (MSB_FIRST != 0) shreg <= shreg << SYMBOL_BITS;
      else                shreg <= shreg >> SYMBOL_BITS;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign head   = (MSB_FIRST != 0) ? shreg[WIDTH-1 -: SYMBOL_BITS]
                                   : shreg[SYMBOL_BITS-1:0];
  assign symbol = enable ? head : '0;
  assign last   = (cnt == CNT_LAST);

endmodule

// File: rtl/piso_serializer.sv
// Double-buffered parallel-in/serial-out serializer. Words enter a one-word
// holding register over valid/ready and are moved into the shifter, which
// emits SYMBOL_BITS bits per `active` strobe.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   parallel        : input word (WIDTH bits)
//   parallel_valid  : word present on `parallel`
//   parallel_ready  : holding register free (forced low during reset)
//   active          : symbol strobe
//   serial_symbol   : current symbol, 0 when idle
//   serial_valid    : serial_symbol carries real data
//   underrun        : one-cycle pulse when the shifter runs dry with no word held
// Build option: PISO_SERIALIZER_REPEAT_EN -- on underrun, replay the last
// loaded word instead of going idle (continuous carrier).
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYMBOL_BITS = 1,
  parameter int MSB_FIRST   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       parallel,
  input  logic                   parallel_valid,
  output logic                   parallel_ready,
  input  logic                   active,
  output logic [SYMBOL_BITS-1:0] serial_symbol,
  output logic                   serial_valid,
  output logic                   underrun
);

  if (!params_ok(WIDTH, SYMBOL_BITS)) begin : g_param_check
    $error("piso_serializer: SYMBOL_BITS must divide WIDTH with at least 2 symbols per word");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             accept;
  logic             load_hold;
  logic             exhaust;
  logic             shift_en;
  logic             last;
  logic             core_load;
  logic [WIDTH-1:0] core_word;

  assign parallel_ready = !hold_full && !reset;
  assign accept         = parallel_valid && parallel_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (hold_full) state_next = SHIFTING;
      SHIFTING: begin
`ifdef PISO_SERIALIZER_REPEAT_EN
        state_next = SHIFTING;
`else
        if (active && last && !hold_full) state_next = IDLE;
`endif
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    load_hold = 1'b0;
    exhaust   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE:     load_hold = hold_full;
      SHIFTING: begin
        if (active) begin
          if (!last)          shift_en  = 1'b1;
          else if (hold_full) load_hold = 1'b1;
          else                exhaust   = 1'b1;
        end
      end
      default:  ;
    endcase
  end

  // Accept needs hold empty and a drain needs it full, so the two never
  // collide; written as set/clear anyway so no word can be dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (accept) hold <= parallel;
      hold_full <= (hold_full && !load_hold) || accept;
      underrun  <= exhaust;
    end
  end

`ifdef PISO_SERIALIZER_REPEAT_EN
  logic [WIDTH-1:0] last_word;

  always_ff @(posedge clk) begin
    if (reset)          last_word <= '0;
    else if (load_hold) last_word <= hold;
  end

  assign core_load = load_hold || exhaust;
  assign core_word = load_hold ? hold : last_word;
`else
  assign core_load = load_hold;
  assign core_word = hold;
`endif

  assign serial_valid = (state == SHIFTING);

  piso_shift_core #(
    .WIDTH       (WIDTH),
    .SYMBOL_BITS (SYMBOL_BITS),
    .MSB_FIRST   (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (core_load),
    .load_word (core_word),
    .shift     (shift_en),
    .enable    (serial_valid),
    .symbol    (serial_symbol),
    .last      (last)
  );

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] parallel = 8'h00;
  logic       parallel_valid = 1'b0;
  logic       active = 1'b0;

  logic       ready_lsb, valid_lsb, und_lsb;
  logic [1:0] sym_lsb;
  logic       ready_msb, valid_msb, und_msb;
  logic [1:0] sym_msb;
  logic       ready_rep, valid_rep, und_rep;
  logic [0:0] sym_rep;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .SYMBOL_BITS(2), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .parallel(parallel), .parallel_valid(parallel_valid),
    .parallel_ready(ready_lsb), .active(active), .serial_symbol(sym_lsb),
    .serial_valid(valid_lsb), .underrun(und_lsb));

  piso_serializer #(.WIDTH(8), .SYMBOL_BITS(2), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .parallel(parallel), .parallel_valid(parallel_valid),
    .parallel_ready(ready_msb), .active(active), .serial_symbol(sym_msb),
    .serial_valid(valid_msb), .underrun(und_msb));

  piso_serializer #(.WIDTH(4), .SYMBOL_BITS(1), .MSB_FIRST(0)) dut_rep (
    .clk(clk), .reset(reset), .parallel(parallel[3:0]), .parallel_valid(parallel_valid),
    .parallel_ready(ready_rep), .active(active), .serial_symbol(sym_rep),
    .serial_valid(valid_rep), .underrun(und_rep));

  // Reference model: per instance, the word being sent and the index of the
  // symbol on the output, plus the one-word buffer in front of it.
  int         m_width [3] = '{8, 8, 4};
  int         m_sb    [3] = '{2, 2, 1};
  int         m_msb   [3] = '{0, 1, 0};
  string      m_name  [3] = '{"lsb", "msb", "rep"};
  bit         m_busy  [3];
  bit         m_hfull [3];
  bit         m_und   [3];
  int         m_k     [3];
  logic [7:0] m_word  [3];
  logic [7:0] m_hold  [3];
  logic [7:0] m_last  [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sym(input int i);
    int pos;
    int wmask;
    int smask;
    if (!m_busy[i]) return 32'd0;
    wmask = (1 << m_width[i]) - 1;
    smask = (1 << m_sb[i]) - 1;
    pos = (m_msb[i] != 0) ? (m_width[i] - (m_k[i] + 1) * m_sb[i]) : (m_k[i] * m_sb[i]);
    return 32'(((int'(m_word[i]) & wmask) >> pos) & smask);
  endfunction

  function automatic logic [31:0] dut_val(input int i, input int what);
    logic [31:0] r;
    r = 32'd0;
    case (i)
      0: case (what) 0: r = 32'(valid_lsb); 1: r = 32'(sym_lsb); 2: r = 32'(und_lsb); default: r = 32'(ready_lsb); endcase
      1: case (what) 0: r = 32'(valid_msb); 1: r = 32'(sym_msb); 2: r = 32'(und_msb); default: r = 32'(ready_msb); endcase
      default: case (what) 0: r = 32'(valid_rep); 1: r = 32'(sym_rep); 2: r = 32'(und_rep); default: r = 32'(ready_rep); endcase
    endcase
    return r;
  endfunction

  task automatic model_update();
    bit acc;
    int nsym;
    for (int i = 0; i < 3; i++) begin
      nsym = m_width[i] / m_sb[i];
      if (reset) begin
        m_busy[i] = 0; m_hfull[i] = 0; m_und[i] = 0; m_k[i] = 0;
        m_word[i] = '0; m_hold[i] = '0; m_last[i] = '0;
      end else begin
        acc = parallel_valid && !m_hfull[i];
        m_und[i] = 0;
        if (!m_busy[i]) begin
          if (m_hfull[i]) begin
            m_busy[i] = 1; m_word[i] = m_hold[i]; m_last[i] = m_hold[i];
            m_k[i] = 0; m_hfull[i] = 0;
          end
        end else if (active) begin
          if (m_k[i] < nsym - 1) begin
            m_k[i]++;
          end else if (m_hfull[i]) begin
            m_word[i] = m_hold[i]; m_last[i] = m_hold[i];
            m_k[i] = 0; m_hfull[i] = 0;
          end else begin
            m_und[i] = 1;
            if (REPEAT) begin
              m_word[i] = m_last[i]; m_k[i] = 0;
            end else begin
              m_busy[i] = 0; m_k[i] = 0;
            end
          end
        end
        if (acc) begin
          m_hold[i]  = (m_width[i] == 4) ? (parallel & 8'h0F) : parallel;
          m_hfull[i] = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_valid", m_name[i]), dut_val(i, 0), 32'(m_busy[i]));
      check($sformatf("%s_symbol", m_name[i]), dut_val(i, 1), exp_sym(i));
      check($sformatf("%s_underrun", m_name[i]), dut_val(i, 2), 32'(m_und[i]));
      check($sformatf("%s_ready", m_name[i]), dut_val(i, 3), 32'(!m_hfull[i] && !reset));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; parallel_valid = 1'b0; active = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int         exp_l [4] = '{0, 1, 3, 2};
  int         exp_m [4] = '{2, 3, 1, 0};
  int         exp_bb[8] = '{0, 1, 3, 2, 3, 3, 0, 0};
  int         exp_rp[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  int         got_q[$];
  int         und_seen;
  bit         gap;

  initial begin
    // reset state
    step();
    step();
    check("reset_ready_low", 32'(ready_lsb), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(ready_lsb), 32'd1);

    // single word, both bit orders, then underrun
    parallel = 8'hB4; parallel_valid = 1'b1;
    step();
    parallel_valid = 1'b0;
    step();
    check("first_sym_lsb", 32'(sym_lsb), 32'(exp_l[0]));
    check("first_sym_msb", 32'(sym_msb), 32'(exp_m[0]));
    active = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("sym_lsb_%0d", k), 32'(sym_lsb), 32'(exp_l[k]));
      check($sformatf("sym_msb_%0d", k), 32'(sym_msb), 32'(exp_m[k]));
    end
    step();
    check("underrun_pulse", 32'(und_lsb), 32'd1);
    check("valid_after_underrun", 32'(valid_lsb), 32'(REPEAT));
    active = 1'b0;
    step();
    check("underrun_one_cycle", 32'(und_lsb), 32'd0);

    // back-to-back streaming
    do_reset();
    parallel = 8'hB4; parallel_valid = 1'b1; active = 1'b1;
    step();
    parallel = 8'h0F;
    got_q.delete(); und_seen = 0; gap = 0;
    for (int c = 0; c < 20 && got_q.size() < 8; c++) begin
      step();
      if (c == 1) parallel_valid = 1'b0;
      if (und_lsb) und_seen++;
      if (valid_lsb) got_q.push_back(int'(sym_lsb));
      else if (got_q.size() > 0) gap = 1;
    end
    check("b2b_count", 32'(got_q.size()), 32'd8);
    check("b2b_gap", 32'(gap), 32'd0);
    check("b2b_underrun", 32'(und_seen), 32'd0);
    for (int j = 0; j < 8 && j < got_q.size(); j++)
      check($sformatf("b2b_sym_%0d", j), 32'(got_q[j]), 32'(exp_bb[j]));
    active = 1'b0;

    // backpressure: both buffers full, third word waits for the reload
    do_reset();
    parallel = 8'hB4; parallel_valid = 1'b1;
    step();
    parallel = 8'h0F;
    step();
    step();
    parallel = 8'h5A;
    step();
    step();
    check("bp_ready_stalled", 32'(ready_lsb), 32'd0);
    active = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check("bp_ready_before_drain", 32'(ready_lsb), 32'd0);
    end
    step();
    check("bp_ready_after_drain", 32'(ready_lsb), 32'd1);
    active = 1'b0;
    step();
    check("bp_third_accepted", 32'(ready_lsb), 32'd0);
    parallel_valid = 1'b0;
    active = 1'b1;
    for (int s = 0; s < 10; s++) step();
    active = 1'b0;

    // reset in the middle of a word
    do_reset();
    parallel = 8'hB4; parallel_valid = 1'b1;
    step();
    parallel_valid = 1'b0;
    step();
    active = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    check("midreset_valid", 32'(valid_lsb), 32'd0);
    check("midreset_symbol", 32'(sym_lsb), 32'd0);
    check("midreset_underrun", 32'(und_lsb), 32'd0);
    reset = 1'b0;
    #1;
    check("midreset_ready", 32'(ready_lsb), 32'd1);
    active = 1'b0;
    step();

    // replay of the last word (4-bit instance, word 0110)
    do_reset();
    parallel = 8'h06; parallel_valid = 1'b1;
    step();
    parallel_valid = 1'b0;
    step();
    got_q.delete(); und_seen = 0; gap = 0;
    got_q.push_back(int'(sym_rep));
    active = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step();
      if (und_rep) und_seen++;
      if (s < 7) begin
        got_q.push_back(int'(sym_rep));
        if (!valid_rep) gap = 1;
      end
    end
    active = 1'b0;
    if (REPEAT) begin
      check("rep_underrun_count", 32'(und_seen), 32'd1);
      check("rep_valid_held", 32'(gap), 32'd0);
      for (int j = 0; j < 8; j++)
        check($sformatf("rep_sym_%0d", j), 32'(got_q[j]), 32'(exp_rp[j]));
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      parallel_valid = $urandom_range(0, 1) == 1;
      parallel       = 8'($urandom);
      active         = $urandom_range(0, 3) != 0;
      step();
    end
    reset = 1'b0; parallel_valid = 1'b0; active = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
